vga_write_arbiter: RTL
======================

Name: vga_write_arbiter

Overview:
Shares the single VGA pixel write port between up to NUM_REQ renderer sub-modules, such as greeting, playing and game-over drawers or a background clear. Requesters are granted in round-robin order. Each grant lasts for one burst, and only the granted requester's pixels reach VGA_X/VGA_Y/VGA_COLOR. The block sits between fsm_game_state's renderers and the VGA adapter, and replaces ad-hoc output muxing.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_BURST, 20000, maximum burst length in cycles before forced release (at least 2)
CNT_W, 15, burst counter width; must satisfy 2^CNT_W >= MAX_BURST

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  when low, no new grants are issued; a burst already in progress completes
req  in  NUM_REQ  per-requester burst request, held high for the whole burst
done  in  NUM_REQ  per-requester end-of-burst pulse, coincident with the last pixel
req_wr  in  NUM_REQ  per-requester pixel write strobe
req_x  in  NUM_REQ*8  packed X coordinates, requester i at bits [8i+7:8i]
req_y  in  NUM_REQ*7  packed Y coordinates
req_color  in  NUM_REQ*12  packed colours
grant  out  NUM_REQ  one-hot grant, registered
VGA_X  out  8  registered pixel X
VGA_Y  out  7  registered pixel Y
VGA_COLOR  out  12  registered pixel colour
VGA_WRITE  out  1  registered write strobe
busy  out  1  high in the GRANT state
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (asynchronous, resetn=0):
  - Outputs: grant=0, VGA_X/Y/COLOR=0, VGA_WRITE=0, busy=0, timeout_err=0.
  - State: IDLE, burst counter=0, last-grant pointer=NUM_REQ-1, so requester 0 wins the first arbitration.
- A reset asserted mid-burst drops grant and VGA_WRITE immediately, with no completion.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If enable=1 and req!=0, pick the first set req bit searching upward from pointer+1 with wrap-around.
  - Next cycle: state=GRANT, grant=onehot(winner), pointer=winner, counter=0.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT:
  - Each cycle, VGA_X/Y/COLOR <= granted requester's fields and VGA_WRITE <= req_wr[g]. Pixel latency is 1 cycle.
  - The pixel fields update only when req_wr[g]=1; otherwise they hold their previous values.
  - req_wr, x, y and color from non-granted requesters are ignored entirely.
  - The counter increments every cycle.
  - Exit to RELEASE when any of these holds:
    - done[g]=1: the pixel written in that same cycle is still forwarded.
    - req[g]=0: that cycle's req_wr[g] is not forwarded.
    - counter==MAX_BURST-1 with done[g]=0: timeout_err pulses for 1 cycle, aligned with grant falling.
  - If done and timeout coincide, done wins and timeout_err stays 0.
- RELEASE:
  - Lasts exactly 1 cycle: grant=0, VGA_WRITE=0, busy=0.
  - Then returns to IDLE, and arbitration resumes in IDLE's next evaluation.
  - Minimum gap between consecutive bursts: grant low for 2 cycles (RELEASE + IDLE).
- enable:
  - Sampled only in IDLE.
  - Dropping enable during GRANT does not shorten the burst.
- done or req_wr pulses outside the grant are ignored and have no lasting effect.
- At most one grant bit is ever high; grant!=0 if and only if state==GRANT.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the VGA field widths (X=8, Y=7, COLOR=12), shared with fsm_game_state.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: req, pointer.
  - Outputs: one-hot winner, winner index, valid.
  - Reusable for other shared resources.

Test Plan:
- Reset then req=3'b111 held: grant=001 one cycle after resetn rises. Each burst is ended by a done pulse on the granted requester, giving grant sequence 001, 010, 100, 001 with a 2-cycle grant-low gap between bursts.
- Requester 1 granted, req_wr[1]=1, x=8'd10, y=7'd20, color=12'hF00; requester 0 simultaneously drives req_wr=1, x=99 -> next cycle VGA_X=10, VGA_Y=20, VGA_COLOR=F00, VGA_WRITE=1; requester 0's data never appears.
- MAX_BURST=4, requester 2 holds req and never pulses done -> grant[2] high exactly 4 cycles, timeout_err=1 for 1 cycle aligned with grant falling, then requester 0 is granted if requesting.
- done[g] and the timeout on the same cycle -> release with timeout_err=0; the last pixel is still written.
- enable=0 with req=3'b010 -> grant stays 0; enable=1 -> grant=010 next cycle. Dropping enable mid-burst keeps grant until done.
- resetn pulsed low mid-burst -> grant=0, VGA_WRITE=0 immediately (asynchronous); after release, requester 0 has priority again.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// rtl/vga_write_arbiter_pkg.sv - shared state encoding and VGA field widths
package vga_write_arbiter_pkg;

    // Arbiter state encoding; fsm_game_state uses the same values.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // VGA adapter pixel field widths
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 12;

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// rtl/vga_write_arbiter_rr_pick.sv - combinational round-robin priority selector
//
// Searches req upward from pointer+1, wrapping at NUM_REQ, and returns the
// first set bit.
//   req        in  NUM_REQ  request vector
//   pointer    in  PTR_W    index of the last winner
//   winner     out NUM_REQ  one-hot winner (0 when no request)
//   winner_idx out PTR_W    binary index of the winner
//   valid      out 1        at least one request present
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               valid
);

    // One extra bit so pointer+k never overflows before the wrap subtract.
    logic [PTR_W:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        // k = 1 is the highest priority candidate (just after the last winner);
        // k = NUM_REQ lands back on the last winner itself.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, pointer} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (!valid && req[cand[PTR_W-1:0]]) begin
                valid                     = 1'b1;
                winner[cand[PTR_W-1:0]]   = 1'b1;
                winner_idx                = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin arbiter for the shared VGA pixel write port
//
// Ports:
//   clock       in  1            system clock
//   resetn      in  1            asynchronous active-low reset
//   enable      in  1            allows new grants (sampled in IDLE only)
//   req         in  NUM_REQ      per-requester burst request
//   done        in  NUM_REQ      per-requester end-of-burst pulse (with last pixel)
//   req_wr      in  NUM_REQ      per-requester pixel write strobe
//   req_x       in  NUM_REQ*8    packed X, requester i at [8i+7:8i]
//   req_y       in  NUM_REQ*7    packed Y
//   req_color   in  NUM_REQ*12   packed colour
//   grant       out NUM_REQ      registered one-hot grant
//   VGA_X       out 8            registered pixel X
//   VGA_Y       out 7            registered pixel Y
//   VGA_COLOR   out 12           registered pixel colour
//   VGA_WRITE   out 1            registered write strobe
//   busy        out 1            high while in GRANT
//   timeout_err out 1            one-cycle pulse when a burst is forcibly released
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 20000,
    parameter int CNT_W     = 15
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [NUM_REQ*8-1:0]   req_x,
    input  logic [NUM_REQ*7-1:0]   req_y,
    input  logic [NUM_REQ*12-1:0]  req_color,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             VGA_X,
    output logic [6:0]             VGA_Y,
    output logic [11:0]            VGA_COLOR,
    output logic                   VGA_WRITE,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic                wr_q, wr_d;
    logic                tmo_q, tmo_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;

    // Unpacked views of the packed per-requester buses, indexed by the pointer.
    logic [X_W-1:0]      x_arr     [NUM_REQ];
    logic [Y_W-1:0]      y_arr     [NUM_REQ];
    logic [COLOR_W-1:0]  color_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign x_arr[i]     = req_x[X_W*i +: X_W];
        assign y_arr[i]     = req_y[Y_W*i +: Y_W];
        assign color_arr[i] = req_color[COLOR_W*i +: COLOR_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .pointer    (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // While in GRANT the pointer holds the granted index, so it doubles as
    // the data-path mux select.
    logic g_req, g_done, g_wr;
    assign g_req  = req[ptr_q];
    assign g_done = done[ptr_q];
    assign g_wr   = req_wr[ptr_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        wr_d    = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (enable && pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!g_req) begin
                    // Requester abandoned the burst: its strobe this cycle is dropped.
                    state_d = RELEASE;
                    grant_d = '0;
                end else begin
                    wr_d = g_wr;
                    if (g_wr) begin
                        x_d     = x_arr[ptr_q];
                        y_d     = y_arr[ptr_q];
                        color_d = color_arr[ptr_q];
                    end
                    if (g_done) begin
                        // done takes precedence over a coincident timeout
                        state_d = RELEASE;
                        grant_d = '0;
                    end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = RELEASE;
                        grant_d = '0;
                        tmo_d   = 1'b1;
                    end
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            wr_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            wr_q    <= wr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign VGA_X       = x_q;
    assign VGA_Y       = y_q;
    assign VGA_COLOR   = color_q;
    assign VGA_WRITE   = wr_q;
    assign busy        = (state_q == GRANT);
    assign timeout_err = tmo_q;

endmodule
